// File: rtl/pio_poll_pkg.sv
// Shared types and parameter legality limits for the PIO poll master.
package pio_poll_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        LAT,
        CAP
    } state_e;

    localparam int unsigned READ_LATENCY_MIN = 1;
    localparam int unsigned READ_LATENCY_MAX = 4;
    localparam int unsigned POLL_DIV_MARGIN  = 3;

    // A poll period must fit one full REQ/LAT/CAP pass plus the IDLE hop.
    function automatic int unsigned poll_div_min(input int unsigned read_latency);
        return read_latency + POLL_DIV_MARGIN;
    endfunction

endpackage

// File: rtl/pio_poll_timer.sv
// Poll period down-counter: POLL_DIV-1 .. 0 while enabled, held at POLL_DIV-1 otherwise.
module pio_poll_timer #(
    parameter int unsigned POLL_DIV = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable_i,
    output logic tick_o
);

    localparam int unsigned     CNT_W  = $clog2(POLL_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(POLL_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable_i || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // The tick fires on the edge that brings the count to zero.
    assign tick_o = enable_i && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pio_poll_master.sv
// Avalon-MM read initiator that periodically polls an input PIO and flags value changes.
module pio_poll_master
    import pio_poll_pkg::*;
#(
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned POLL_DIV     = 1000,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned POLL_ADDR    = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              changed,
    output logic              irq,
    input  logic              irq_clear,
    output logic              overrun,
    output logic [15:0]       poll_count
);

    localparam int unsigned LAT_W = 3;

    generate
        if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
            $error("pio_poll_master: READ_LATENCY out of range 1..4");
        end
        if (POLL_DIV < poll_div_min(READ_LATENCY)) begin : g_bad_poll_div
            $error("pio_poll_master: POLL_DIV below READ_LATENCY+3");
        end
    endgenerate

    logic tick;

    pio_poll_timer #(
        .POLL_DIV (POLL_DIV)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable_i (enable),
        .tick_o   (tick)
    );

    state_e            state_q,   state_d;
    logic              due_q,     due_d;
    logic [LAT_W-1:0]  lat_q,     lat_d;
    logic              enable_q;
    logic              first_q,   first_d;
    logic [DATA_W-1:0] prev_q,    prev_d;
    logic [DATA_W-1:0] sample_q,  sample_d;
    logic              valid_q,   valid_d;
    logic              changed_q, changed_d;
    logic              irq_q,     irq_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       count_q,   count_d;
    logic              read_q,    read_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              consume;

    always_comb begin
        state_d   = state_q;
        due_d     = due_q;
        lat_d     = lat_q;
        first_d   = first_q;
        prev_d    = prev_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;
        irq_d     = irq_q;
        overrun_d = overrun_q;
        count_d   = count_q;
        consume   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (due_q && enable) begin
                    state_d = REQ;
                    consume = 1'b1;
                end
            end
            REQ: begin
                if (!avm_waitrequest) begin
                    lat_d   = LAT_W'(READ_LATENCY);
                    state_d = LAT;
                end
            end
            LAT: begin
                // Capture lands on the edge READ_LATENCY cycles after acceptance.
                if (lat_q == LAT_W'(1)) begin
                    sample_d  = avm_readdata;
                    valid_d   = 1'b1;
                    changed_d = (avm_readdata != prev_q) || first_q;
                    prev_d    = avm_readdata;
                    first_d   = 1'b0;
                    count_d   = count_q + 16'd1;
                    state_d   = CAP;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            CAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enable && !enable_q) begin
            first_d = 1'b1;
        end

        // A tick arriving on the edge that consumes due is not a drop.
        if (!enable) begin
            due_d = 1'b0;
        end else if (tick) begin
            if (due_q && !consume) begin
                overrun_d = 1'b1;
            end
            due_d = 1'b1;
        end else if (consume) begin
            due_d = 1'b0;
        end

        if (changed_d) begin
            irq_d = 1'b1;
        end else if (irq_clear) begin
            irq_d = 1'b0;
        end

        read_d = (state_d == REQ);
        addr_d = read_d ? ADDR_W'(POLL_ADDR) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            due_q     <= 1'b0;
            lat_q     <= '0;
            enable_q  <= 1'b0;
            first_q   <= 1'b1;
            prev_q    <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            irq_q     <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
            read_q    <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            due_q     <= due_d;
            lat_q     <= lat_d;
            enable_q  <= enable;
            first_q   <= first_d;
            prev_q    <= prev_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            irq_q     <= irq_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
            read_q    <= read_d;
            addr_q    <= addr_d;
        end
    end

    assign avm_address  = addr_q;
    assign avm_read     = read_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign changed      = changed_q;
    assign irq          = irq_q;
    assign overrun      = overrun_q;
    assign poll_count   = count_q;

endmodule

// File: tb/tb_pio_poll_master.sv
// Directed bench for pio_poll_master: table of polls plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_pio_poll_master;

    localparam int unsigned P = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        enable;
    logic        wait_r;
    logic        irq_clear;
    logic [31:0] rdata;
    logic [31:0] rdata3;

    logic [1:0]  addr1, addr3;
    logic        read1, read3;
    logic [31:0] sample1, sample3;
    logic        valid1, valid3, chg1, chg3, irq1, irq3, ovr1, ovr3;
    logic [15:0] cnt1, cnt3;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    always @(posedge clk) cycle <= cycle + 1;

    pio_poll_master #(
        .ADDR_W       (2),
        .DATA_W       (32),
        .POLL_DIV     (P),
        .READ_LATENCY (1),
        .POLL_ADDR    (0)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .avm_address     (addr1),
        .avm_read        (read1),
        .avm_waitrequest (wait_r),
        .avm_readdata    (rdata),
        .sample          (sample1),
        .sample_valid    (valid1),
        .changed         (chg1),
        .irq             (irq1),
        .irq_clear       (irq_clear),
        .overrun         (ovr1),
        .poll_count      (cnt1)
    );

    pio_poll_master #(
        .ADDR_W       (2),
        .DATA_W       (32),
        .POLL_DIV     (P),
        .READ_LATENCY (3),
        .POLL_ADDR    (2)
    ) dut3 (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .avm_address     (addr3),
        .avm_read        (read3),
        .avm_waitrequest (wait_r),
        .avm_readdata    (rdata3),
        .sample          (sample3),
        .sample_valid    (valid3),
        .changed         (chg3),
        .irq             (irq3),
        .irq_clear       (irq_clear),
        .overrun         (ovr3),
        .poll_count      (cnt3)
    );

    typedef struct {
        logic [31:0] rdata;
        int          clr;     // 0 none, 1 early pulse, 2 held across the capture edge
        logic        chg;
        logic [31:0] sample;
        logic        irq;
        logic [15:0] count;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read"},    32'(read1),   32'h0);
        check({tag, "_addr"},    32'(addr1),   32'h0);
        check({tag, "_sample"},  sample1,      32'h0);
        check({tag, "_valid"},   32'(valid1),  32'h0);
        check({tag, "_changed"}, 32'(chg1),    32'h0);
        check({tag, "_irq"},     32'(irq1),    32'h0);
        check({tag, "_overrun"}, 32'(ovr1),    32'h0);
        check({tag, "_count"},   32'(cnt1),    32'h0);
        check({tag, "_l3_irq"},  32'(irq3),    32'h0);
        check({tag, "_l3_ovr"},  32'(ovr3),    32'h0);
        check({tag, "_l3_chg"},  32'(chg3),    32'h0);
        check({tag, "_l3_cnt"},  32'(cnt3),    32'h0);
    endtask

    task automatic wait_valid(output logic found);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (valid1) found = 1'b1;
        end
        if (!found) check("sample_valid_timeout", 32'(found), 32'h1);
    endtask

    task automatic wait_read(input logic use3, output logic found);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (use3 ? read3 : read1) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) check("avm_read_timeout", 32'(found), 32'h1);
    endtask

    // Assert reset, check reset values, release, and check first-launch timing.
    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        enable    = 1'b1;
        wait_r    = 1'b0;
        irq_clear = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (P - 1) @(negedge clk);
        check("read_before_launch", 32'(read1), 32'h0);
        @(negedge clk);
        check("read_at_launch", 32'(read1), 32'h1);
        check("addr_at_launch", 32'(addr1), 32'h0);
        @(negedge clk);
        check("read_single_cycle", 32'(read1), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        found;
        int          last;
        int          nvalid;
        int          nread;
        logic [15:0] pc0;
        logic [31:0] held;
        logic [31:0] v3 [5];

        vecs[0] = '{32'h0000_00A5, 0, 1'b1, 32'h0000_00A5, 1'b1, 16'd1};
        vecs[1] = '{32'h0000_00A5, 1, 1'b0, 32'h0000_00A5, 1'b0, 16'd2};
        vecs[2] = '{32'h0000_00A5, 0, 1'b0, 32'h0000_00A5, 1'b0, 16'd3};
        vecs[3] = '{32'h0000_005A, 0, 1'b1, 32'h0000_005A, 1'b1, 16'd4};
        vecs[4] = '{32'h0000_005A, 0, 1'b0, 32'h0000_005A, 1'b1, 16'd5};
        vecs[5] = '{32'h0000_005A, 1, 1'b0, 32'h0000_005A, 1'b0, 16'd6};
        vecs[6] = '{32'h0000_00A5, 2, 1'b1, 32'h0000_00A5, 1'b1, 16'd7};

        reset_n   = 1'b0;
        enable    = 1'b1;
        wait_r    = 1'b0;
        irq_clear = 1'b0;
        rdata     = 32'h0000_00A5;
        rdata3    = 32'h0;
        do_reset();

        // Periodic polling, change detection and irq behaviour.
        last = 0;
        for (int i = 0; i < 7; i++) begin
            rdata = vecs[i].rdata;
            if (vecs[i].clr == 1) begin
                irq_clear = 1'b1;
                @(negedge clk);
                irq_clear = 1'b0;
            end else if (vecs[i].clr == 2) begin
                irq_clear = 1'b1;
            end
            wait_valid(found);
            if (found) begin
                check($sformatf("v%0d_changed", i), 32'(chg1),  32'(vecs[i].chg));
                check($sformatf("v%0d_sample", i),  sample1,    vecs[i].sample);
                check($sformatf("v%0d_irq", i),     32'(irq1),  32'(vecs[i].irq));
                check($sformatf("v%0d_count", i),   32'(cnt1),  32'(vecs[i].count));
                if (i > 0) check($sformatf("v%0d_spacing", i), 32'(cycle - last), 32'(P));
                last = cycle;
            end
            irq_clear = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_valid_pulse", i), 32'(valid1), 32'h0);
            check($sformatf("v%0d_changed_pulse", i), 32'(chg1), 32'h0);
        end

        // Stalled request: held stable, tick dropped, one completion on release.
        check("overrun_before_stall", 32'(ovr1), 32'h0);
        pc0 = cnt1;
        wait_read(1'b0, found);
        wait_r = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            check($sformatf("stall%0d_read", n), 32'(read1), 32'h1);
            check($sformatf("stall%0d_addr", n), 32'(addr1), 32'h0);
        end
        wait_r = 1'b0;
        nvalid = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (valid1) nvalid++;
        end
        check("stall_completions", 32'(nvalid), 32'h1);
        check("stall_count", 32'(cnt1), 32'(pc0 + 16'd1));
        @(negedge clk);
        check("stall_overrun", 32'(ovr1), 32'h1);

        // Enable dropped just after acceptance: capture still happens, then silence.
        wait_read(1'b0, found);
        @(negedge clk);
        enable = 1'b0;
        wait_valid(found);
        held = sample1;
        nread = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (read1) nread++;
        end
        check("disabled_reads", 32'(nread), 32'h0);
        enable = 1'b1;
        wait_valid(found);
        if (found) begin
            check("reenable_changed", 32'(chg1), 32'h1);
            check("reenable_sample", sample1, held);
        end

        // Asynchronous reset while a request is outstanding.
        wait_read(1'b0, found);
        wait_r = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async");
        wait_r = 1'b0;
        do_reset();

        // Latency 3: only the value present on the capture edge is taken.
        v3[0] = 32'h1111_1111;
        v3[1] = 32'h2222_2222;
        v3[2] = 32'h3333_3333;
        v3[3] = 32'hCAFE_F00D;
        v3[4] = 32'h5555_5555;
        wait_read(1'b1, found);
        check("l3_addr", 32'(addr3), 32'h2);
        for (int k = 0; k < 5; k++) begin
            rdata3 = v3[k];
            @(negedge clk);
            if (k == 2) check("l3_early_valid", 32'(valid3), 32'h0);
            if (k == 3) begin
                check("l3_valid", 32'(valid3), 32'h1);
                check("l3_sample", sample3, 32'hCAFE_F00D);
            end
            if (k == 4) begin
                check("l3_late_valid", 32'(valid3), 32'h0);
                check("l3_sample_held", sample3, 32'hCAFE_F00D);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pio_poll_master.md
# pio_poll_master

Avalon-MM read initiator that periodically polls a 32-bit input PIO slave, such as the quadrature/limit-switch input PIOs on the lightweight HPS-to-FPGA fabric. Each read result is captured and compared with the previous one, and the block raises a sticky interrupt when the value changes. This lets FPGA-side motion logic and the HPS react to input changes without software polling. It sits between an input PIO's s1 port and the motion-control fabric.

## Interface
Parameters:
- ADDR_W, 2, avm_address width
- DATA_W, 32, data width
- POLL_DIV, 1000, clk cycles between poll launches; legal minimum READ_LATENCY+3
- READ_LATENCY, 1, fixed slave read latency in cycles; legal range 1..4
- POLL_ADDR, 0, word address of the slave data register

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- enable  in  1  polling enable
- avm_address  out  ADDR_W  read address
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_W  slave read data
- sample  out  DATA_W  last captured value
- sample_valid  out  1  one-cycle pulse per completed poll
- changed  out  1  one-cycle pulse with sample_valid when sample differs from previous
- irq  out  1  sticky change interrupt
- irq_clear  in  1  clears irq
- overrun  out  1  sticky; a poll tick was dropped
- poll_count  out  16  completed polls; wraps 0xFFFF->0

## Operation
- States are IDLE, REQ, LAT, CAP.
- Period timer: while enable=1, counts POLL_DIV-1 down to 0, reloads, and emits a tick at 0. While enable=0 it holds at POLL_DIV-1.
- A tick sets `due`. If `due` is already set, the tick is dropped and overrun is set.
- IDLE -> REQ when due=1 and enable=1; due clears.
- REQ: avm_read=1 and avm_address=POLL_ADDR. The request holds unchanged while avm_waitrequest=1. On an edge where waitrequest=0, load the latency counter with READ_LATENCY and go to LAT.
- LAT: decrement the counter. When it reaches 1, go to CAP.
- CAP: register avm_readdata into sample and pulse sample_valid. changed = (readdata != prev) or first_sample. Then prev <= readdata, first_sample <= 0, poll_count+1, and return to IDLE.
- first_sample is set by reset and by a 0->1 edge of enable, so the first poll always reports changed=1.
- irq: set on changed. Cleared by irq_clear. If both occur in the same cycle, set wins.
- overrun is cleared only by reset.
- enable dropping mid-transaction does not abort the read; the transaction completes, the capture still occurs, then the FSM stays in IDLE with due cleared.
- Reset mid-transaction: all state returns to reset values immediately. avm_read drops asynchronously.

## Timing
- Reset values: avm_read=0, avm_address=0, sample=0, sample_valid=0, changed=0, irq=0, overrun=0, poll_count=0; timer=POLL_DIV-1; state IDLE.
- All outputs are registered.
- Tick at edge t: avm_read is high after edge t+1.
- Acceptance at edge a: avm_readdata is sampled at edge a+READ_LATENCY, and sample/sample_valid are visible after that edge.
- Launch spacing with waitrequest=0: exactly POLL_DIV cycles.
- One outstanding read maximum; avm_read is never asserted in LAT or CAP.

## Structure
- Package pio_poll_pkg holds the state enum (IDLE, REQ, LAT, CAP) and the POLL_DIV/READ_LATENCY legality limits.
- One sub-module, pio_poll_timer: the period down-counter with enable and tick output.
- The FSM, capture, compare and irq logic stay in the top level.
- Parameter legality is checked by elaboration-time assertion.

## Test plan
- POLL_DIV=8, READ_LATENCY=1, waitrequest=0, slave returns 0x0000_00A5 constant -> read launches every 8 cycles. The first sample_valid has changed=1 and irq=1; later polls have changed=0. poll_count increments per poll.
- Slave value steps 0xA5->0x5A between polls -> exactly one changed pulse with sample=0x5A. irq stays set until irq_clear, and a clear in the same cycle as a change leaves irq=1.
- waitrequest held high for 12 cycles with POLL_DIV=8 -> avm_read and avm_address stable throughout, overrun=1, and exactly one read completes after release.
- READ_LATENCY=3 -> capture occurs 3 edges after acceptance. A distinct value driven on readdata only at that edge is captured; values on neighbouring edges are not.
- enable deasserted in the cycle after acceptance -> the capture still occurs, with no further reads. Re-enable -> the first capture reports changed=1 even if the value is unchanged.
- reset_n asserted while in REQ -> avm_read=0 asynchronously and all outputs return to reset values. After release, the first read launches POLL_DIV cycles later. poll_count wraps 0xFFFF->0x0000.
